// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, operand classes and the canonical quiet NaN.
// Widths are parameters of the users, so the NaN pattern comes from a constant function.
package fpu_pkg;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rm_e;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    localparam int FP_MAX_W = 64;

    // Quiet NaN: sign 0, all-ones exponent, mantissa MSB set; truncate to 1+exp_w+man_w.
    function automatic logic [FP_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FP_MAX_W; i++)
            if (i >= man_w - 1 && i < man_w + exp_w) v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one operand into sign, exponent, significand and class.
// Subnormals are reported as zero with a cleared significand.
module fp_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] x,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       sig,
    output fp_class_e            cls
);

    logic e_zero, e_ones, m_zero;

    assign e_zero = (x[EXP_W+MAN_W-1:MAN_W] == '0);
    assign e_ones = (x[EXP_W+MAN_W-1:MAN_W] == '1);
    assign m_zero = (x[MAN_W-1:0] == '0);

    always_comb begin
        sign = x[EXP_W+MAN_W];
        exp  = x[EXP_W+MAN_W-1:MAN_W];
        sig  = {1'b1, x[MAN_W-1:0]};
        cls  = FP_NORM;
        if (e_ones) begin
            cls = m_zero ? FP_INF : FP_NAN;
        end else if (e_zero) begin
            cls = FP_ZERO;
            exp = '0;
            sig = '0;
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier with valid/ready flow control and a carried tag.
// Stage 1 holds the raw significand product; later stages hold the rounded result.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic                 rm,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 ovf,
    output logic                 udf
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EMAX = 2**EXP_W - 1;
    localparam int OD   = (STAGES >= 2) ? STAGES - 1 : 1;
    localparam logic [W-1:0] CANON_NAN = W'(canon_nan(EXP_W, MAN_W));

    typedef struct packed {
        logic             sign;
        fp_class_e        cls;
        logic [XW-1:0]    exp;
        logic [PW-1:0]    prod;
        rm_e              rm;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [W-1:0]     y;
        logic             ovf;
        logic             udf;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic              en;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:1]   vld_q;

    logic [1:0][W-1:0]     ops;
    logic [1:0]            op_sign;
    logic [1:0][EXP_W-1:0] op_exp;
    logic [1:0][SW-1:0]    op_sig;
    fp_class_e             op_cls [2];

    req_t s1, m;
    rsp_t r;
    rsp_t res_q [OD];

    // One shared enable: any stall freezes the whole pipe, so no bubble squeezing is needed.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign vld_pipe  = {vld_q, in_valid && in_ready};
    assign out_valid = vld_q[STAGES];

    always_ff @(posedge clk) begin
        if (rst)     vld_q <= '0;
        else if (en) vld_q <= vld_pipe[STAGES-1:0];
    end

    assign ops = {x2, x1};

    for (genvar i = 0; i < 2; i++) begin : g_cls
        fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls (
            .x    (ops[i]),
            .sign (op_sign[i]),
            .exp  (op_exp[i]),
            .sig  (op_sig[i]),
            .cls  (op_cls[i])
        );
    end

    always_comb begin
        s1      = '0;
        s1.sign = op_sign[0] ^ op_sign[1];
        s1.prod = {{SW{1'b0}}, op_sig[0]} * {{SW{1'b0}}, op_sig[1]};
        s1.exp  = XW'(op_exp[0]) + XW'(op_exp[1]) - XW'(BIAS);
        s1.rm   = rm_e'(rm);
        s1.tag  = in_tag;
        if (op_cls[0] == FP_NAN || op_cls[1] == FP_NAN ||
            (op_cls[0] == FP_INF && op_cls[1] == FP_ZERO) ||
            (op_cls[0] == FP_ZERO && op_cls[1] == FP_INF))
            s1.cls = FP_NAN;
        else if (op_cls[0] == FP_INF || op_cls[1] == FP_INF)
            s1.cls = FP_INF;
        else if (op_cls[0] == FP_ZERO || op_cls[1] == FP_ZERO)
            s1.cls = FP_ZERO;
        else
            s1.cls = FP_NORM;
    end

    if (STAGES >= 2) begin : g_mid
        req_t m_q;
        always_ff @(posedge clk) begin
            if (rst)     m_q <= '0;
            else if (en) m_q <= s1;
        end
        assign m = m_q;
    end else begin : g_nomid
        assign m = s1;
    end

    logic [PW-2:0]    norm;
    logic [MAN_W-1:0] mant;
    logic             g, rb, st, inc;
    logic [MAN_W:0]   mant_r;
    logic [XW-1:0]    e_fin;
    logic             e_lo, e_hi;

    always_comb begin
        // Product is in [1,4): drop the leading one, shifting left once if it sits one bit low.
        norm   = m.prod[PW-1] ? m.prod[PW-2:0] : {m.prod[PW-3:0], 1'b0};
        mant   = norm[PW-2 -: MAN_W];
        g      = norm[MAN_W];
        rb     = norm[MAN_W-1];
        st     = |norm[MAN_W-2:0];
        inc    = (m.rm == RM_RNE) && g && (rb || st || mant[0]);
        mant_r = {1'b0, mant} + SW'(inc);
        e_fin  = m.exp + XW'(m.prod[PW-1]) + XW'(mant_r[MAN_W]);
        e_lo   = $signed(e_fin) < $signed(XW'(1));
        e_hi   = $signed(e_fin) >= $signed(XW'(EMAX));

        r     = '0;
        r.tag = m.tag;
        case (m.cls)
            FP_NAN:  r.y = CANON_NAN;
            FP_INF:  r.y = {m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            FP_ZERO: r.y = {m.sign, {(W-1){1'b0}}};
            default: begin
                if (e_lo) begin
                    r.y   = {m.sign, {(W-1){1'b0}}};
                    r.udf = 1'b1;
                end else if (e_hi) begin
                    r.ovf = 1'b1;
                    if (m.rm == RM_RNE)
                        r.y = {m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    else
                        r.y = {m.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                end else begin
                    r.y = {m.sign, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OD; i++) res_q[i] <= '0;
        end else if (en) begin
            res_q[0] <= r;
            for (int i = 1; i < OD; i++) res_q[i] <= res_q[i-1];
        end
    end

    assign y       = res_q[OD-1].y;
    assign out_tag = res_q[OD-1].tag;
    assign ovf     = res_q[OD-1].ovf;
    assign udf     = res_q[OD-1].udf;

endmodule
